// File: rtl/dmem_arb_pkg.sv
// dmem_arbiter shared types: channel FSM state, port index, port count.
// Imported by dmem_arb_chan and dmem_arbiter.
package dmem_arb_pkg;

  localparam int NPORT = 2;

  typedef enum logic {
    IDLE = 1'b0,
    HOLD = 1'b1
  } arb_state_e;

  typedef logic port_t;

endpackage

// File: rtl/dmem_arb_chan.sv
// One arbitrated channel: winner select, grant hold while target stalls.
// Ports: clk, resetb, req[1:0], m_valid in; m_ready, win, acc[1:0] out.
module dmem_arb_chan
  import dmem_arb_pkg::*;
#(
  parameter int FIXED_PRIO = 0
) (
  input  logic             clk,
  input  logic             resetb,
  input  logic [NPORT-1:0] req,
  input  logic             m_valid,
  output logic             m_ready,
  output port_t            win,
  output logic [NPORT-1:0] acc
);

  arb_state_e state_q, state_d;
  port_t      gnt_q, gnt_d;
  port_t      pri_q, pri_d;
  logic       xfer;

  always_ff @(posedge clk or negedge resetb) begin
    if (!resetb) begin
      state_q <= IDLE;
      gnt_q   <= 1'b0;
      pri_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      gnt_q   <= gnt_d;
      pri_q   <= pri_d;
    end
  end

  always_comb begin
    state_d = state_q;
    gnt_d   = gnt_q;
    pri_d   = pri_q;
    win     = 1'b0;
    acc     = '0;

    unique case (state_q)
      IDLE: begin
        if (req[0] && req[1]) begin
          win = (FIXED_PRIO != 0) ? 1'b0 : pri_q;
        end else begin
          win = req[1];
        end
      end
      HOLD: win = gnt_q;
      default: win = 1'b0;
    endcase

    m_ready  = req[win];
    xfer     = m_ready && m_valid;
    acc[win] = xfer;

    unique case (state_q)
      IDLE: begin
        if (xfer) begin
          pri_d = ~win;
        end else if (m_ready) begin
          state_d = HOLD;
          gnt_d   = win;
        end
      end
      HOLD: begin
        if (xfer) begin
          state_d = IDLE;
          pri_d   = ~gnt_q;
        end else if (!req[gnt_q]) begin
          // requester abandoned its grant: release, keep pri
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

endmodule

// File: rtl/dmem_arbiter.sv
// Two-port data-memory arbiter: independent W/R channels, read return routing.
// Optional perf counters (perf_grant0/1, perf_conflict) with DMEM_ARB_PERF_EN.
module dmem_arbiter
  import dmem_arb_pkg::*;
#(
  parameter int FIXED_PRIO = 0,
  parameter int CNT_W      = 32
) (
  input  logic             clk,
  input  logic             resetb,
  input  logic             p0_wready,
  input  logic             p1_wready,
  output logic             p0_wvalid,
  output logic             p1_wvalid,
  input  logic [31:0]      p0_waddr,
  input  logic [31:0]      p0_wdata,
  input  logic [31:0]      p1_waddr,
  input  logic [31:0]      p1_wdata,
  input  logic [3:0]       p0_wstrb,
  input  logic [3:0]       p1_wstrb,
  input  logic             p0_rready,
  input  logic             p1_rready,
  output logic             p0_rvalid,
  output logic             p1_rvalid,
  input  logic [31:0]      p0_raddr,
  input  logic [31:0]      p1_raddr,
  output logic             p0_rresp,
  output logic             p1_rresp,
  output logic [31:0]      p0_rdata,
  output logic [31:0]      p1_rdata,
  output logic             m_wready,
  output logic             m_rready,
  input  logic             m_wvalid,
  input  logic             m_rvalid,
  output logic [31:0]      m_waddr,
  output logic [31:0]      m_wdata,
  output logic [31:0]      m_raddr,
  output logic [3:0]       m_wstrb,
`ifdef DMEM_ARB_PERF_EN
  output logic [CNT_W-1:0] perf_grant0,
  output logic [CNT_W-1:0] perf_grant1,
  output logic [CNT_W-1:0] perf_conflict,
`endif
  input  logic             m_rresp,
  input  logic [31:0]      m_rdata
);

  logic [NPORT-1:0] wreq, rreq;
  logic [NPORT-1:0] wacc, racc;
  port_t            wwin, rwin;
  port_t            rown_q;
  logic             rpend_q;

  assign wreq = {p1_wready, p0_wready};
  assign rreq = {p1_rready, p0_rready};

  dmem_arb_chan #(
    .FIXED_PRIO(FIXED_PRIO)
  ) u_w (
    .clk    (clk),
    .resetb (resetb),
    .req    (wreq),
    .m_valid(m_wvalid),
    .m_ready(m_wready),
    .win    (wwin),
    .acc    (wacc)
  );

  dmem_arb_chan #(
    .FIXED_PRIO(FIXED_PRIO)
  ) u_r (
    .clk    (clk),
    .resetb (resetb),
    .req    (rreq),
    .m_valid(m_rvalid),
    .m_ready(m_rready),
    .win    (rwin),
    .acc    (racc)
  );

  assign m_waddr = wwin ? p1_waddr : p0_waddr;
  assign m_wdata = wwin ? p1_wdata : p0_wdata;
  assign m_wstrb = wwin ? p1_wstrb : p0_wstrb;
  assign m_raddr = rwin ? p1_raddr : p0_raddr;

  assign p0_wvalid = wacc[0];
  assign p1_wvalid = wacc[1];
  assign p0_rvalid = racc[0];
  assign p1_rvalid = racc[1];

  always_ff @(posedge clk or negedge resetb) begin
    if (!resetb) begin
      rown_q  <= 1'b0;
      rpend_q <= 1'b0;
    end else begin
      rpend_q <= |racc;
      if (|racc) rown_q <= rwin;
    end
  end

  always_comb begin
    p0_rdata = '0;
    p1_rdata = '0;
    p0_rresp = 1'b0;
    p1_rresp = 1'b0;
    if (rpend_q) begin
      if (rown_q) begin
        p1_rdata = m_rdata;
        p1_rresp = m_rresp;
      end else begin
        p0_rdata = m_rdata;
        p0_rresp = m_rresp;
      end
    end
  end

`ifdef DMEM_ARB_PERF_EN
  always_ff @(posedge clk or negedge resetb) begin
    if (!resetb) begin
      perf_grant0   <= '0;
      perf_grant1   <= '0;
      perf_conflict <= '0;
    end else begin
      perf_grant0   <= perf_grant0
                     + CNT_W'(wacc[0])
                     + CNT_W'(racc[0]);
      perf_grant1   <= perf_grant1
                     + CNT_W'(wacc[1])
                     + CNT_W'(racc[1]);
      perf_conflict <= perf_conflict
                     + CNT_W'(&wreq)
                     + CNT_W'(&rreq);
    end
  end
`endif

endmodule

// File: tb/tb_dmem_arbiter.sv
// Self-checking bench for dmem_arbiter: vector table, read scoreboard,
// fixed-priority instance and async reset with a pending read return.
module tb_dmem_arbiter;

  localparam logic [31:0] P0_WA = 32'h0000_0020;
  localparam logic [31:0] P1_WA = 32'h0000_0010;
  localparam logic [31:0] P0_WD = 32'h1111_2222;
  localparam logic [31:0] P1_WD = 32'h3333_4444;
  localparam logic [3:0]  P0_ST = 4'hF;
  localparam logic [3:0]  P1_ST = 4'h3;
  localparam logic [31:0] P0_RA = 32'h0000_1000;
  localparam logic [31:0] P1_RA = 32'h0000_0030;
  localparam logic [31:0] XORK  = 32'hDEAD_AEEF;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        resetb;
  logic        p0_wready, p1_wready, p0_rready, p1_rready;
  logic [31:0] p0_waddr, p0_wdata, p1_waddr, p1_wdata;
  logic [3:0]  p0_wstrb, p1_wstrb;
  logic [31:0] p0_raddr, p1_raddr;
  logic        m_wvalid, m_rvalid, m_rresp;
  logic [31:0] m_rdata;

  logic        p0_wvalid, p1_wvalid, p0_rvalid, p1_rvalid;
  logic        p0_rresp, p1_rresp;
  logic [31:0] p0_rdata, p1_rdata;
  logic        m_wready, m_rready;
  logic [31:0] m_waddr, m_wdata, m_raddr;
  logic [3:0]  m_wstrb;

  logic        f_p0_wvalid, f_p1_wvalid, f_p0_rvalid, f_p1_rvalid;
  logic        f_p0_rresp, f_p1_rresp;
  logic [31:0] f_p0_rdata, f_p1_rdata;
  logic        f_m_wready, f_m_rready;
  logic [31:0] f_m_waddr, f_m_wdata, f_m_raddr;
  logic [3:0]  f_m_wstrb;

`ifdef DMEM_ARB_PERF_EN
  logic [31:0] perf_grant0, perf_grant1, perf_conflict;
  logic [31:0] f_perf_grant0, f_perf_grant1, f_perf_conflict;
`endif

  dmem_arbiter #(.FIXED_PRIO(0), .CNT_W(32)) dut (
    .clk(clk), .resetb(resetb),
    .p0_wready(p0_wready), .p1_wready(p1_wready),
    .p0_wvalid(p0_wvalid), .p1_wvalid(p1_wvalid),
    .p0_waddr(p0_waddr), .p0_wdata(p0_wdata),
    .p1_waddr(p1_waddr), .p1_wdata(p1_wdata),
    .p0_wstrb(p0_wstrb), .p1_wstrb(p1_wstrb),
    .p0_rready(p0_rready), .p1_rready(p1_rready),
    .p0_rvalid(p0_rvalid), .p1_rvalid(p1_rvalid),
    .p0_raddr(p0_raddr), .p1_raddr(p1_raddr),
    .p0_rresp(p0_rresp), .p1_rresp(p1_rresp),
    .p0_rdata(p0_rdata), .p1_rdata(p1_rdata),
    .m_wready(m_wready), .m_rready(m_rready),
    .m_wvalid(m_wvalid), .m_rvalid(m_rvalid),
    .m_waddr(m_waddr), .m_wdata(m_wdata),
    .m_raddr(m_raddr), .m_wstrb(m_wstrb),
`ifdef DMEM_ARB_PERF_EN
    .perf_grant0(perf_grant0), .perf_grant1(perf_grant1),
    .perf_conflict(perf_conflict),
`endif
    .m_rresp(m_rresp), .m_rdata(m_rdata)
  );

  dmem_arbiter #(.FIXED_PRIO(1), .CNT_W(32)) dut_fp (
    .clk(clk), .resetb(resetb),
    .p0_wready(p0_wready), .p1_wready(p1_wready),
    .p0_wvalid(f_p0_wvalid), .p1_wvalid(f_p1_wvalid),
    .p0_waddr(p0_waddr), .p0_wdata(p0_wdata),
    .p1_waddr(p1_waddr), .p1_wdata(p1_wdata),
    .p0_wstrb(p0_wstrb), .p1_wstrb(p1_wstrb),
    .p0_rready(p0_rready), .p1_rready(p1_rready),
    .p0_rvalid(f_p0_rvalid), .p1_rvalid(f_p1_rvalid),
    .p0_raddr(p0_raddr), .p1_raddr(p1_raddr),
    .p0_rresp(f_p0_rresp), .p1_rresp(f_p1_rresp),
    .p0_rdata(f_p0_rdata), .p1_rdata(f_p1_rdata),
    .m_wready(f_m_wready), .m_rready(f_m_rready),
    .m_wvalid(m_wvalid), .m_rvalid(m_rvalid),
    .m_waddr(f_m_waddr), .m_wdata(f_m_wdata),
    .m_raddr(f_m_raddr), .m_wstrb(f_m_wstrb),
`ifdef DMEM_ARB_PERF_EN
    .perf_grant0(f_perf_grant0), .perf_grant1(f_perf_grant1),
    .perf_conflict(f_perf_conflict),
`endif
    .m_rresp(m_rresp), .m_rdata(m_rdata)
  );

  // memory model: returns addr ^ XORK one cycle after an accepted read
  always @(posedge clk) begin
    if (m_rready && m_rvalid) begin
      m_rdata <= m_raddr ^ XORK;
      m_rresp <= 1'b1;
    end else begin
      m_rdata <= '0;
      m_rresp <= 1'b0;
    end
  end

  typedef struct {
    logic [1:0] w;
    logic [1:0] r;
    logic       mwv;
    logic       mrv;
    logic       emw;
    logic       emr;
    logic [1:0] ewa;
    logic [1:0] era;
    logic       ews;
    logic       ers;
    logic       fp;
  } vec_t;

  typedef struct {
    logic        port;
    logic [31:0] data;
  } ret_t;

  vec_t tbl[$];
  ret_t sb[$];
  int   checks = 0;
  int   errors = 0;

  function automatic vec_t mk(
    logic [1:0] w, logic [1:0] r, logic mwv, logic mrv,
    logic emw, logic emr, logic [1:0] ewa, logic [1:0] era,
    logic ews, logic ers, logic fp);
    vec_t v;
    v.w = w; v.r = r; v.mwv = mwv; v.mrv = mrv;
    v.emw = emw; v.emr = emr; v.ewa = ewa; v.era = era;
    v.ews = ews; v.ers = ers; v.fp = fp;
    return v;
  endfunction

  task automatic chk(input string name, input logic [31:0] act,
                     input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s act=%h exp=%h t=%0t", name, act, exp, $time);
    end
  endtask

  task automatic drive(input logic [1:0] w, input logic [1:0] r,
                       input logic mwv, input logic mrv);
    {p1_wready, p0_wready} = w;
    {p1_rready, p0_rready} = r;
    m_wvalid = mwv;
    m_rvalid = mrv;
  endtask

  task automatic chk_ret();
    ret_t e;
    if (sb.size() > 0) begin
      e = sb.pop_front();
      chk("p0_rdata", p0_rdata, e.port ? 32'h0 : e.data);
      chk("p1_rdata", p1_rdata, e.port ? e.data : 32'h0);
      chk("rresp", {30'h0, p1_rresp, p0_rresp},
          e.port ? 32'h2 : 32'h1);
    end else begin
      chk("p0_rdata_idle", p0_rdata, 32'h0);
      chk("p1_rdata_idle", p1_rdata, 32'h0);
      chk("rresp_idle", {30'h0, p1_rresp, p0_rresp}, 32'h0);
    end
  endtask

  // called at posedge+1; returns at next posedge+1
  task automatic apply(input vec_t v);
    ret_t e;
    drive(v.w, v.r, v.mwv, v.mrv);
    #6;
    chk("m_wready", {31'h0, m_wready}, {31'h0, v.emw});
    chk("m_rready", {31'h0, m_rready}, {31'h0, v.emr});
    chk("wvalid", {30'h0, p1_wvalid, p0_wvalid}, {30'h0, v.ewa});
    chk("rvalid", {30'h0, p1_rvalid, p0_rvalid}, {30'h0, v.era});
    if (v.emw) begin
      chk("m_waddr", m_waddr, v.ews ? P1_WA : P0_WA);
      chk("m_wdata", m_wdata, v.ews ? P1_WD : P0_WD);
      chk("m_wstrb", {28'h0, m_wstrb},
          {28'h0, v.ews ? P1_ST : P0_ST});
    end
    if (v.emr) chk("m_raddr", m_raddr, v.ers ? P1_RA : P0_RA);
    chk_ret();
    if (v.fp) begin
      chk("fp_rvalid", {30'h0, f_p1_rvalid, f_p0_rvalid}, 32'h1);
      chk("fp_m_raddr", f_m_raddr, P0_RA);
    end
    if (v.era != 2'b00) begin
      e.port = v.era[1];
      e.data = (v.era[1] ? P1_RA : P0_RA) ^ XORK;
      sb.push_back(e);
    end
    @(posedge clk);
    #1;
  endtask

  initial begin
    resetb = 1'b0;
    drive(2'b00, 2'b00, 1'b0, 1'b0);
    p0_waddr = '0; p0_wdata = '0; p1_waddr = '0; p1_wdata = '0;
    p0_wstrb = '0; p1_wstrb = '0; p0_raddr = '0; p1_raddr = '0;

    // w, r, mwv, mrv, emw, emr, ewa, era, ews, ers, fp
    tbl.push_back(mk(2'b00, 2'b00, 0, 0, 0, 0, 2'b00, 2'b00, 0, 0, 0));
    tbl.push_back(mk(2'b00, 2'b01, 0, 1, 0, 1, 2'b00, 2'b01, 0, 0, 0));
    tbl.push_back(mk(2'b00, 2'b00, 0, 0, 0, 0, 2'b00, 2'b00, 0, 0, 0));
    tbl.push_back(mk(2'b11, 2'b00, 1, 0, 1, 0, 2'b01, 2'b00, 0, 0, 0));
    tbl.push_back(mk(2'b11, 2'b00, 1, 0, 1, 0, 2'b10, 2'b00, 1, 0, 0));
    tbl.push_back(mk(2'b11, 2'b00, 1, 0, 1, 0, 2'b01, 2'b00, 0, 0, 0));
    tbl.push_back(mk(2'b11, 2'b00, 1, 0, 1, 0, 2'b10, 2'b00, 1, 0, 0));
    tbl.push_back(mk(2'b10, 2'b00, 0, 0, 1, 0, 2'b00, 2'b00, 1, 0, 0));
    tbl.push_back(mk(2'b11, 2'b00, 0, 0, 1, 0, 2'b00, 2'b00, 1, 0, 0));
    tbl.push_back(mk(2'b11, 2'b00, 0, 0, 1, 0, 2'b00, 2'b00, 1, 0, 0));
    tbl.push_back(mk(2'b11, 2'b00, 1, 0, 1, 0, 2'b10, 2'b00, 1, 0, 0));
    tbl.push_back(mk(2'b01, 2'b00, 1, 0, 1, 0, 2'b01, 2'b00, 0, 0, 0));
    tbl.push_back(mk(2'b01, 2'b10, 1, 1, 1, 1, 2'b01, 2'b10, 0, 1, 0));
    tbl.push_back(mk(2'b00, 2'b00, 0, 0, 0, 0, 2'b00, 2'b00, 0, 0, 0));
    tbl.push_back(mk(2'b00, 2'b01, 0, 0, 0, 1, 2'b00, 2'b00, 0, 0, 0));
    tbl.push_back(mk(2'b00, 2'b10, 0, 1, 0, 0, 2'b00, 2'b00, 0, 0, 0));
    tbl.push_back(mk(2'b00, 2'b11, 0, 1, 0, 1, 2'b00, 2'b01, 0, 0, 0));
    tbl.push_back(mk(2'b00, 2'b11, 0, 1, 0, 1, 2'b00, 2'b10, 0, 1, 0));
    tbl.push_back(mk(2'b00, 2'b00, 0, 0, 0, 0, 2'b00, 2'b00, 0, 0, 0));
    tbl.push_back(mk(2'b10, 2'b10, 1, 1, 1, 1, 2'b10, 2'b10, 1, 1, 0));
    tbl.push_back(mk(2'b00, 2'b00, 0, 0, 0, 0, 2'b00, 2'b00, 0, 0, 0));
    for (int i = 0; i < 4; i++) begin
      tbl.push_back(mk(2'b00, 2'b11, 0, 1, 0, 1, 2'b00,
                       i[0] ? 2'b10 : 2'b01, 0, i[0], 1));
    end
    tbl.push_back(mk(2'b00, 2'b00, 0, 0, 0, 0, 2'b00, 2'b00, 0, 0, 0));

    repeat (2) @(posedge clk);
    #1;
    resetb = 1'b1;
    #6;
    chk("reset_ctl",
        {26'h0, m_wready, m_rready, p0_wvalid, p1_wvalid,
         p0_rvalid, p1_rvalid}, 32'h0);
    chk("reset_m_waddr", m_waddr | m_wdata | m_raddr, 32'h0);
    chk("reset_m_wstrb", {28'h0, m_wstrb}, 32'h0);
    chk("reset_rdata", p0_rdata | p1_rdata, 32'h0);
    @(posedge clk);
    #1;

    p0_waddr = P0_WA; p0_wdata = P0_WD; p0_wstrb = P0_ST;
    p1_waddr = P1_WA; p1_wdata = P1_WD; p1_wstrb = P1_ST;
    p0_raddr = P0_RA; p1_raddr = P1_RA;

    foreach (tbl[i]) apply(tbl[i]);

    // W held on p1 and p1 read accepted, then reset before the return
    apply(mk(2'b10, 2'b10, 0, 1, 1, 1, 2'b00, 2'b10, 1, 1, 0));
    drive(2'b00, 2'b00, 1'b0, 1'b0);
    resetb = 1'b0;
    #2;
    sb.delete();
    chk("rst_p1_rdata", p1_rdata, 32'h0);
    chk("rst_p0_rdata", p0_rdata, 32'h0);
    chk("rst_rresp", {30'h0, p1_rresp, p0_rresp}, 32'h0);
`ifdef DMEM_ARB_PERF_EN
    chk("rst_perf_g0", perf_grant0, 32'h0);
    chk("rst_perf_g1", perf_grant1, 32'h0);
    chk("rst_perf_cf", perf_conflict, 32'h0);
`endif
    #2;
    resetb = 1'b1;
    @(posedge clk);
    #1;
    apply(mk(2'b11, 2'b00, 1, 0, 1, 0, 2'b01, 2'b00, 0, 0, 0));
    apply(mk(2'b00, 2'b00, 0, 0, 0, 0, 2'b00, 2'b00, 0, 0, 0));

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/dmem_arbiter.md
# dmem_arbiter

Two-requester, single-target arbiter for the data-memory bus. It shares one data RAM between the core's dmem port (port 0) and a secondary master (port 1, loader/debug/DMA). Write and read channels are arbitrated independently. Each grant is held stable while the target stalls, and read data is routed back to the requester that owns it.

## Interface
- FIXED_PRIO, 0: 0 = round-robin; 1 = port 0 always wins contention.
- CNT_W, 32: width of performance counters (only with DMEM_ARB_PERF_EN).
- clk  in  1  clock
- resetb  in  1  asynchronous active-low reset
- p0_wready, p1_wready  in  1  write request from port n
- p0_wvalid, p1_wvalid  out  1  write accepted for port n
- p0_waddr/p0_wdata, p1_waddr/p1_wdata  in  32  write address/data
- p0_wstrb, p1_wstrb  in  4  byte strobes
- p0_rready, p1_rready  in  1  read request from port n
- p0_rvalid, p1_rvalid  out  1  read accepted for port n
- p0_raddr, p1_raddr  in  32  read address
- p0_rresp, p1_rresp  out  1  read response OK, cycle after accept
- p0_rdata, p1_rdata  out  32  read data, cycle after accept
- m_wready, m_rready  out  1  request to memory
- m_wvalid, m_rvalid  in  1  memory accepts (same cycle)
- m_waddr, m_wdata, m_raddr  out  32  muxed address/data
- m_wstrb  out  4  muxed strobes
- m_rresp  in  1; m_rdata  in  32  memory read return, cycle after accept
- perf_grant0, perf_grant1, perf_conflict  out  CNT_W  counters (DMEM_ARB_PERF_EN only)

## Operation
- Protocol: a transfer occurs when ready && valid in the same cycle. Address, data and strobes must be held until the transfer.
- Per channel (W, R): state IDLE or HOLD; a grant register gnt (0/1); a priority pointer pri.
- IDLE: select a winner among requesters.
  - Single requester wins.
  - Both requesting: winner = pri (round-robin) or port 0 (FIXED_PRIO=1).
  - m_*ready = winner's request. Mux winner's address/data/strobes to m_*.
  - Winner's *valid = m_*valid; loser's valid = 0.
  - Transfer: stay IDLE; pri <= other port.
  - Request but no transfer: go to HOLD with gnt <= winner.
- HOLD: the grant is locked to gnt. The other requester is ignored.
  - Transfer: go to IDLE; pri <= other port.
  - If the granted requester drops its request (protocol violation), go to IDLE with no pri change.
- Read return: on an R transfer, rown_q <= winner and rpend_q <= 1; otherwise rpend_q <= 0.
  - When rpend_q is set, p[rown_q]_rdata/rresp = m_rdata/m_rresp.
  - All non-owner rdata and rresp are 0. Both ports read 0 when rpend_q is clear.
- W and R channels may transfer in the same cycle, to different or the same port.
- Neither channel ever issues a memory request without a requester request.

## Timing
- Arbitration decision and m_* request are combinational from inputs and state: 0 cycles of added request latency.
- Back-to-back transfers are possible every cycle. Under continuous contention in round-robin mode, grants alternate 0,1,0,1.
- Read data returns exactly 1 cycle after the R transfer, as seen by the memory.
- Reset values: W and R state IDLE; gnt=0; pri=0 (port 0 first); rown_q=0; rpend_q=0; counters 0.
- With all inputs low after reset, every output is 0.
- Reset asserted mid-HOLD or with a read return pending: state, rpend_q and counters clear immediately. A pending return is dropped, and p*_rdata reads 0.

## Configuration
- DMEM_ARB_PERF_EN defined:
  - perf_grant0/1 increment on each W or R transfer of that port; +2 if both channels transfer for the port in the same cycle.
  - perf_conflict increments each cycle both ports request the same channel, +1 per channel.
  - All counters wrap at 2^CNT_W.
- Undefined: perf ports absent and no counter flops.

## Structure
- Package dmem_arb_pkg holds: arb_state_e {IDLE, HOLD}, the port index type, and NPORT=2.
- Sub-module dmem_arb_chan: one channel's arbiter FSM with gnt/pri. Instantiated twice (W, R); the R instance additionally exports the winner for rown_q.
- Top level holds the muxes, return routing and perf counters.

## Test plan
- Only p0 reads 0x0000_1000, memory accepts immediately and returns 0xDEADBEEF next cycle -> p0_rvalid=1 at the accept; p0_rdata=0xDEADBEEF and rresp=1 next cycle; p1_rdata=0.
- p0 and p1 write continuously, m_wvalid=1, round-robin -> m_waddr alternates p0, p1, p0, p1 starting with p0 after reset.
- p1 writes 0x10 while m_wvalid=0 for 3 cycles, p0 requests from cycle 2 -> grant stays on p1 through HOLD; p1 transfers on cycle 4; p0 transfers on cycle 5.
- FIXED_PRIO=1, both read continuously for 4 cycles -> p0 wins all 4; p1_rvalid=0 throughout.
- Simultaneous p0 write (0x20, strb 0xF) and p1 read (0x30) -> both transfer in the same cycle; return routed to p1 only.
- resetb pulsed low the cycle after a p1 read accept -> p1_rdata=0, state IDLE, pri=0; with DMEM_ARB_PERF_EN, all counters read 0.
